branch_predictor: RTL and testbench

- Parametrised fetch-stage PC predictor for the pipelined Y86-64 core.
- Replaces the fixed always-taken policy with a direct-mapped table of 2-bit saturating counters for conditional jXX.
- Unconditional jmp and call are still predicted taken to valC.
- Sits beside fetch and drives f_predPC; execute feeds resolved outcomes back to train the table and flag mispredicts.

---
 rtl/branch_predictor.sv | 172 +++++++++++++++++
 tb/tb_branch_predictor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage PC predictor: 2-bit counter table for jXX, taken for jmp/call.
// Optional return-address stack enabled by defining RAS_EN.
module branch_predictor #(
    parameter int AW           = 64,
    parameter int IDXW         = 4,
    parameter int TAGW         = 8,
    parameter int STATIC_TAKEN = 1,
    parameter int CNTW         = 32,
    parameter int RAS_DEPTH    = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   f_pc,
    input  logic [3:0]      f_icode,
    input  logic [3:0]      f_ifun,
    input  logic [AW-1:0]   f_valC,
    input  logic [AW-1:0]   f_valP,
    input  logic            f_stall,
    output logic [AW-1:0]   f_predPC,
    output logic            f_pred_taken,
    output logic            f_ret_pred,
    input  logic            e_update,
    input  logic [AW-1:0]   e_pc,
    input  logic            e_Cnd,
    input  logic            e_pred_taken,
    output logic            e_mispredict,
    input  logic            ras_flush,
    output logic [CNTW-1:0] perf_branches,
    output logic [CNTW-1:0] perf_mispred
);

    localparam int N = 1 << IDXW;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    logic [N-1:0]    valid_q, valid_d;
    logic [TAGW-1:0] tag_q [N];
    logic [TAGW-1:0] tag_d [N];
    logic [1:0]      ctr_q [N];
    logic [1:0]      ctr_d [N];
    logic [CNTW-1:0] br_q, br_d;
    logic [CNTW-1:0] mis_q, mis_d;

    logic [IDXW-1:0] f_idx, e_idx;
    logic [TAGW-1:0] f_tag, e_tag;
    logic            f_hit, e_hit, cond_taken;

    assign f_idx = f_pc[IDXW-1:0];
    assign f_tag = f_pc[IDXW +: TAGW];
    assign e_idx = e_pc[IDXW-1:0];
    assign e_tag = e_pc[IDXW +: TAGW];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign cond_taken = f_hit ? ctr_q[f_idx][1] : (STATIC_TAKEN != 0);

    assign e_mispredict  = e_update && (e_Cnd != e_pred_taken);
    assign perf_branches = br_q;
    assign perf_mispred  = mis_q;

`ifdef RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] ras_q [RAS_DEPTH];
    logic [AW-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0] sp_q, sp_d, top_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ras_nonempty;
    logic          unused_ok;

    assign top_idx = (sp_q == '0) ? PW'(RAS_DEPTH - 1) : sp_q - 1'b1;
    assign ras_nonempty = (cnt_q != '0);
    assign unused_ok = ^{f_pc, e_pc};

    always_comb begin
        ras_d = ras_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (ras_flush) begin
            cnt_d = '0;
        end else if (!f_stall && f_icode == I_CALL) begin
            // Writing at sp when full overwrites the oldest slot.
            ras_d[sp_q] = f_valP;
            sp_d = (sp_q == PW'(RAS_DEPTH - 1)) ? '0 : sp_q + 1'b1;
            if (cnt_q != CW'(RAS_DEPTH))
                cnt_d = cnt_q + 1'b1;
        end else if (!f_stall && f_icode == I_RET && ras_nonempty) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{f_pc, e_pc, f_stall, ras_flush} ^ (RAS_DEPTH == 0);
`endif

    always_comb begin
        f_predPC     = f_valP;
        f_pred_taken = 1'b0;
        f_ret_pred   = 1'b0;
        if (f_icode == I_CALL || (f_icode == I_JXX && f_ifun == 4'h0)) begin
            f_predPC     = f_valC;
            f_pred_taken = 1'b1;
        end else if (f_icode == I_JXX) begin
            f_pred_taken = cond_taken;
            f_predPC     = cond_taken ? f_valC : f_valP;
        end else if (f_icode == I_RET) begin
`ifdef RAS_EN
            if (ras_nonempty) begin
                f_predPC     = ras_q[top_idx];
                f_pred_taken = 1'b1;
                f_ret_pred   = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        br_d    = br_q;
        mis_d   = mis_q;
        if (e_update) begin
            if (e_hit) begin
                if (e_Cnd && ctr_q[e_idx] != 2'b11)
                    ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
                else if (!e_Cnd && ctr_q[e_idx] != 2'b00)
                    ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
            end else begin
                valid_d[e_idx] = 1'b1;
                tag_d[e_idx]   = e_tag;
                ctr_d[e_idx]   = e_Cnd ? 2'b10 : 2'b01;
            end
            if (~&br_q)
                br_d = br_q + 1'b1;
        end
        if (e_mispredict && ~&mis_q)
            mis_d = mis_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        tag_q <= tag_d;
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++)
                ctr_q[i] <= 2'b01;
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

`ifdef RAS_EN
    always_ff @(posedge clock) begin
        ras_q <= ras_d;
        if (!reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations queued with stimulus,
// drained and compared at the falling edge of each cycle.
module tb_branch_predictor;

    localparam int AW = 64;
    localparam int CNTW = 32;

    localparam int K_PC  = 0;
    localparam int K_TK  = 1;
    localparam int K_RET = 2;
    localparam int K_MIS = 3;
    localparam int K_BR  = 4;
    localparam int K_PM  = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic [AW-1:0]   f_pc, f_valC, f_valP, e_pc;
    logic [3:0]      f_icode, f_ifun;
    logic            f_stall, e_update, e_Cnd, e_pred_taken, ras_flush;
    logic [AW-1:0]   f_predPC;
    logic            f_pred_taken, f_ret_pred, e_mispredict;
    logic [CNTW-1:0] perf_branches, perf_mispred;

    int n_cmp = 0;
    int n_err = 0;

    int          sb_kind [$];
    logic [63:0] sb_val  [$];
    string       sb_tag  [$];

    branch_predictor #(
        .AW(AW), .IDXW(4), .TAGW(8), .STATIC_TAKEN(1),
        .CNTW(CNTW), .RAS_DEPTH(2)
    ) dut (
        .clock(clock), .reset(reset),
        .f_pc(f_pc), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_valC(f_valC), .f_valP(f_valP), .f_stall(f_stall),
        .f_predPC(f_predPC), .f_pred_taken(f_pred_taken),
        .f_ret_pred(f_ret_pred),
        .e_update(e_update), .e_pc(e_pc), .e_Cnd(e_Cnd),
        .e_pred_taken(e_pred_taken), .e_mispredict(e_mispredict),
        .ras_flush(ras_flush),
        .perf_branches(perf_branches), .perf_mispred(perf_mispred)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input int kind, input logic [63:0] v,
                              input string tag);
        sb_kind.push_back(kind);
        sb_val.push_back(v);
        sb_tag.push_back(tag);
    endtask

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_PC:    return f_predPC;
            K_TK:    return {63'd0, f_pred_taken};
            K_RET:   return {63'd0, f_ret_pred};
            K_MIS:   return {63'd0, e_mispredict};
            K_BR:    return {32'd0, perf_branches};
            default: return {32'd0, perf_mispred};
        endcase
    endfunction

    task automatic step();
        @(negedge clock);
        while (sb_kind.size() > 0) begin
            int k;
            logic [63:0] v;
            string t;
            k = sb_kind.pop_front();
            v = sb_val.pop_front();
            t = sb_tag.pop_front();
            check(t, observe(k), v);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] pc, input logic [63:0] vc,
                         input logic [63:0] vp);
        f_icode = ic;
        f_ifun  = fn;
        f_pc    = pc;
        f_valC  = vc;
        f_valP  = vp;
    endtask

    task automatic upd(input logic en, input logic [63:0] pc,
                       input logic cnd, input logic pt);
        e_update     = en;
        e_pc         = pc;
        e_Cnd        = cnd;
        e_pred_taken = pt;
    endtask

    task automatic jxx(input logic [63:0] pc);
        fetch(4'h7, 4'h4, pc, 64'h100, 64'h4A);
    endtask

    initial begin
        reset = 1'b0;
        f_stall = 1'b0;
        ras_flush = 1'b0;
        fetch(4'h1, 4'h0, 64'h0, 64'h0, 64'h0);
        upd(1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        jxx(64'h40);
        expect_val(K_BR, 0, "rst_perf_br");
        expect_val(K_PM, 0, "rst_perf_mis");
        expect_val(K_PC, 64'h100, "rst_miss_pc");
        step();
        reset = 1'b1;

        jxx(64'h40);
        expect_val(K_PC, 64'h100, "miss_static_pc");
        expect_val(K_TK, 1, "miss_static_tk");
        expect_val(K_MIS, 0, "no_upd_mis");
        step();

        // three not-taken updates: alloc 01, then 00, stays 00
        upd(1'b1, 64'h40, 1'b0, 1'b0);
        expect_val(K_PC, 64'h100, "upd1_prebypass");
        expect_val(K_MIS, 0, "upd1_mis");
        step();
        expect_val(K_PC, 64'h4A, "ctr01_pc");
        expect_val(K_TK, 0, "ctr01_tk");
        expect_val(K_BR, 1, "perf_br1");
        step();
        expect_val(K_PC, 64'h4A, "ctr00_pc");
        step();
        upd(1'b0, 64'h0, 1'b0, 1'b0);
        expect_val(K_PC, 64'h4A, "after3_pc");
        expect_val(K_BR, 3, "perf_br3");
        step();

        upd(1'b1, 64'h40, 1'b0, 1'b1);
        expect_val(K_MIS, 1, "mispred_flag");
        step();
        upd(1'b0, 64'h0, 1'b0, 1'b0);
        expect_val(K_PM, 1, "perf_mis1");
        expect_val(K_BR, 4, "perf_br4");
        expect_val(K_MIS, 0, "mis_gated");
        expect_val(K_PC, 64'h4A, "floor00_pc");
        step();

        // 00 -> 01, then same-cycle lookup/update on 01
        upd(1'b1, 64'h40, 1'b1, 1'b0);
        step();
        upd(1'b1, 64'h40, 1'b1, 1'b1);
        expect_val(K_PC, 64'h4A, "samecyc_old");
        expect_val(K_MIS, 0, "samecyc_mis");
        step();
        upd(1'b1, 64'h40, 1'b1, 1'b1);
        expect_val(K_PC, 64'h100, "samecyc_new");
        expect_val(K_BR, 6, "perf_br6");
        expect_val(K_PM, 2, "perf_mis2");
        step();
        upd(1'b1, 64'h40, 1'b1, 1'b1);
        step();
        upd(1'b1, 64'h40, 1'b0, 1'b1);
        step();
        upd(1'b0, 64'h0, 1'b0, 1'b0);
        expect_val(K_PC, 64'h100, "sat11_dec_pc");
        step();
        upd(1'b1, 64'h40, 1'b0, 1'b1);
        step();
        upd(1'b0, 64'h0, 1'b0, 1'b0);
        expect_val(K_PC, 64'h4A, "ctr01_again");
        step();

        fetch(4'h8, 4'h0, 64'h50, 64'h200, 64'h59);
        expect_val(K_PC, 64'h200, "call_pc");
        expect_val(K_TK, 1, "call_tk");
        step();
        fetch(4'h7, 4'h0, 64'h50, 64'h300, 64'h59);
        expect_val(K_PC, 64'h300, "jmp_pc");
        step();
        fetch(4'h6, 4'h0, 64'h50, 64'h300, 64'h52);
        expect_val(K_PC, 64'h52, "opq_pc");
        expect_val(K_TK, 0, "opq_tk");
        step();

        // 0x1040 has the same index and tag as 0x40 and shares the entry
        jxx(64'h40);
        upd(1'b1, 64'h1040, 1'b1, 1'b0);
        step();
        upd(1'b0, 64'h0, 1'b0, 1'b0);
        expect_val(K_PC, 64'h100, "alias_shared");
        step();
        upd(1'b1, 64'h140, 1'b0, 1'b0);
        step();
        upd(1'b0, 64'h0, 1'b0, 1'b0);
        jxx(64'h140);
        expect_val(K_PC, 64'h4A, "evict_new_hit");
        step();
        jxx(64'h40);
        expect_val(K_PC, 64'h100, "evict_old_miss");
        step();

        reset = 1'b0;
        step();
        reset = 1'b1;
        jxx(64'h140);
        expect_val(K_PC, 64'h100, "midrst_miss");
        expect_val(K_BR, 0, "midrst_br");
        expect_val(K_PM, 0, "midrst_mis");
        step();

`ifdef RAS_EN
        fetch(4'h8, 4'h0, 64'h0, 64'h900, 64'h10);
        step();
        fetch(4'h8, 4'h0, 64'h0, 64'h900, 64'h20);
        step();
        fetch(4'h8, 4'h0, 64'h0, 64'h900, 64'h30);
        step();
        fetch(4'h9, 4'h0, 64'h0, 64'h0, 64'h77);
        expect_val(K_PC, 64'h30, "ret1_pc");
        expect_val(K_RET, 1, "ret1_ok");
        expect_val(K_TK, 1, "ret1_tk");
        step();
        expect_val(K_PC, 64'h20, "ret2_pc");
        step();
        expect_val(K_RET, 0, "ret3_empty");
        expect_val(K_PC, 64'h77, "ret3_pc");
        step();
        expect_val(K_RET, 0, "ret4_empty");
        step();
        fetch(4'h8, 4'h0, 64'h0, 64'h900, 64'h60);
        step();
        f_stall = 1'b1;
        fetch(4'h9, 4'h0, 64'h0, 64'h0, 64'h77);
        expect_val(K_PC, 64'h60, "stall_ret_a");
        step();
        f_stall = 1'b0;
        ras_flush = 1'b1;
        expect_val(K_PC, 64'h60, "stall_ret_b");
        step();
        ras_flush = 1'b0;
        expect_val(K_RET, 0, "flush_empty");
        step();
`else
        fetch(4'h9, 4'h0, 64'h0, 64'h0, 64'h77);
        ras_flush = 1'b1;
        expect_val(K_PC, 64'h77, "ret_nopred_pc");
        expect_val(K_RET, 0, "ret_nopred");
        expect_val(K_TK, 0, "ret_tk");
        step();
        ras_flush = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
